vga_timing_gen: RTL and testbench

- Display timing generator for the camera path. It sits directly upstream of the overlay/draw stage.
- Produces the horizontal and vertical pixel counters (X_Cont / Y_Cont) consumed by the overlay stage.
- Issues a read request to the frame-buffer read FIFO one pixel ahead of display.
- Registers the returned RGB pixel and drives the panel's sync, blank and colour outputs, all cycle-aligned.
- Target panel: 800x480 LCD.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/sync_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Desc     : 800x480 panel timing constants shared by timing and overlay stages
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    localparam int unsigned c_H_ACTIVE = 800;
    localparam int unsigned c_H_FP     = 40;
    localparam int unsigned c_H_SYNC   = 128;
    localparam int unsigned c_H_BP     = 88;
    localparam int unsigned c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int unsigned c_V_ACTIVE = 480;
    localparam int unsigned c_V_FP     = 10;
    localparam int unsigned c_V_SYNC   = 2;
    localparam int unsigned c_V_BP     = 33;
    localparam int unsigned c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int unsigned c_H_CNT_W  = 11;
    localparam int unsigned c_V_CNT_W  = 10;
    localparam int unsigned c_CW       = 12;

endpackage
`default_nettype wire

// File: rtl/sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_counter
// Desc     : One timing axis: counter with active, sync and terminal-count flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_counter #(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter int unsigned W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_active,
    output logic         o_sync,
    output logic         o_wrap
);

    localparam int unsigned c_TOTAL     = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] c_LAST     = W'(c_TOTAL - 1);
    localparam logic [W-1:0] c_ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] c_SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] c_SYNC_END = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;
    logic         w_atLast;

    assign w_atLast = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_atLast ? '0 : r_count + W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_active = (r_count < c_ACT_END);
    assign o_sync   = (r_count >= c_SYNC_BEG) && (r_count < c_SYNC_END);
    // Wrap is qualified by the enable so the vertical axis reports end-of-frame
    assign o_wrap   = i_en && w_atLast;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Desc     : Panel timing generator: pixel counters, FIFO read strobe, and
//            cycle-aligned sync/blank/colour outputs two clocks after the counters
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = c_H_ACTIVE,
    parameter int unsigned H_FP     = c_H_FP,
    parameter int unsigned H_SYNC   = c_H_SYNC,
    parameter int unsigned H_BP     = c_H_BP,
    parameter int unsigned V_ACTIVE = c_V_ACTIVE,
    parameter int unsigned V_FP     = c_V_FP,
    parameter int unsigned V_SYNC   = c_V_SYNC,
    parameter int unsigned V_BP     = c_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CW       = c_CW
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [CW-1:0]        iRed,
    input  logic [CW-1:0]        iGreen,
    input  logic [CW-1:0]        iBlue,
    output logic                 oRequest,
    output logic [c_H_CNT_W-1:0] oX_Cont,
    output logic [c_V_CNT_W-1:0] oY_Cont,
    output logic                 oFrameStart,
    output logic [CW-1:0]        oVGA_R,
    output logic [CW-1:0]        oVGA_G,
    output logic [CW-1:0]        oVGA_B,
    output logic                 oHS,
    output logic                 oVS,
    output logic                 oBLANK_N
);

    logic [c_H_CNT_W-1:0] w_hCnt;
    logic [c_V_CNT_W-1:0] w_vCnt;
    logic w_hAct, w_hSync, w_hWrap;
    logic w_vAct, w_vSync, w_vWrap;

    sync_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (c_H_CNT_W)
    ) u_hCounter (
        .clk      (iCLK),
        .rst      (iRST),
        .i_en     (1'b1),
        .o_count  (w_hCnt),
        .o_active (w_hAct),
        .o_sync   (w_hSync),
        .o_wrap   (w_hWrap)
    );

    sync_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (c_V_CNT_W)
    ) u_vCounter (
        .clk      (iCLK),
        .rst      (iRST),
        .i_en     (w_hWrap),
        .o_count  (w_vCnt),
        .o_active (w_vAct),
        .o_sync   (w_vSync),
        .o_wrap   (w_vWrap)
    );

    // Tracks "counters sit at (0,0)" without a full-width compare on both axes
    logic r_atOrigin;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_atOrigin <= 1'b1;
        end else begin
            r_atOrigin <= w_vWrap;
        end
    end

    logic                 r_req;
    logic [c_H_CNT_W-1:0] r_x;
    logic [c_V_CNT_W-1:0] r_y;
    logic                 r_frameStart;
    logic                 r_hs1;
    logic                 r_vs1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_req        <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_frameStart <= 1'b0;
            r_hs1        <= 1'b0;
            r_vs1        <= 1'b0;
        end else begin
            r_req        <= w_hAct && w_vAct;
            r_x          <= w_hCnt;
            r_y          <= w_vCnt;
            r_frameStart <= r_atOrigin;
            r_hs1        <= w_hSync;
            r_vs1        <= w_vSync;
        end
    end

    logic [CW-1:0] r_red;
    logic [CW-1:0] r_green;
    logic [CW-1:0] r_blue;
    logic          r_blankN;
    logic          r_hsPin;
    logic          r_vsPin;

    // FIFO data for a stage-1 request arrives in this cycle; blank pixels read as black
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_blankN <= 1'b0;
            r_hsPin  <= ~HS_POL;
            r_vsPin  <= ~VS_POL;
        end else begin
            r_red    <= r_req ? iRed   : '0;
            r_green  <= r_req ? iGreen : '0;
            r_blue   <= r_req ? iBlue  : '0;
            r_blankN <= r_req;
            r_hsPin  <= r_hs1 ? HS_POL : ~HS_POL;
            r_vsPin  <= r_vs1 ? VS_POL : ~VS_POL;
        end
    end

    assign oRequest    = r_req;
    assign oX_Cont     = r_x;
    assign oY_Cont     = r_y;
    assign oFrameStart = r_frameStart;
    assign oVGA_R      = r_red;
    assign oVGA_G      = r_green;
    assign oVGA_B      = r_blue;
    assign oBLANK_N    = r_blankN;
    assign oHS         = r_hsPin;
    assign oVS         = r_vsPin;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Desc     : Random-stimulus bench for vga_timing_gen on a reduced panel geometry,
//            one instance per sync polarity, against an arithmetic timing model
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int c_HA  = 16;
    localparam int c_HFP = 4;
    localparam int c_HSW = 8;
    localparam int c_HBP = 4;
    localparam int c_HT  = c_HA + c_HFP + c_HSW + c_HBP;
    localparam int c_VA  = 8;
    localparam int c_VFP = 2;
    localparam int c_VSW = 2;
    localparam int c_VBP = 3;
    localparam int c_VT  = c_VA + c_VFP + c_VSW + c_VBP;
    localparam int c_FT  = c_HT * c_VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] red = '0, green = '0, blue = '0;

    logic        req[2];
    logic [10:0] xc[2];
    logic [9:0]  yc[2];
    logic        fs[2];
    logic [11:0] vr[2], vg[2], vb[2];
    logic        hs[2], vs[2], blankN[2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE (c_HA), .H_FP (c_HFP), .H_SYNC (c_HSW), .H_BP (c_HBP),
            .V_ACTIVE (c_VA), .V_FP (c_VFP), .V_SYNC (c_VSW), .V_BP (c_VBP),
            .HS_POL   (gi == 1), .VS_POL (gi == 1), .CW (12)
        ) u_dut (
            .iCLK        (clk),
            .iRST        (rst),
            .iRed        (red),
            .iGreen      (green),
            .iBlue       (blue),
            .oRequest    (req[gi]),
            .oX_Cont     (xc[gi]),
            .oY_Cont     (yc[gi]),
            .oFrameStart (fs[gi]),
            .oVGA_R      (vr[gi]),
            .oVGA_G      (vg[gi]),
            .oVGA_B      (vb[gi]),
            .oHS         (hs[gi]),
            .oVS         (vs[gi]),
            .oBLANK_N    (blankN[gi])
        );
    end

    int          total, bad;
    int          k;            // non-reset clock edges since the last reset edge
    int          cyc, reqIdx, reqCnt, lastFs, guard;
    bit          fsSeen;
    logic [35:0] rgbEdge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit inAct(input int p);
        return ((p % c_HT) < c_HA) && ((p / c_HT) < c_VA);
    endfunction

    function automatic bit inHs(input int p);
        int h = p % c_HT;
        return (h >= c_HA + c_HFP) && (h < c_HA + c_HFP + c_HSW);
    endfunction

    function automatic bit inVs(input int p);
        int v = p / c_HT;
        return (v >= c_VA + c_VFP) && (v < c_VA + c_VFP + c_VSW);
    endfunction

    // Stage-1 outputs show raster position k-1, stage-2 outputs show k-2
    task automatic checkAll();
        int          p1, p2, eX, eY;
        bit          eReq, eFs, eBlank, eHs, eVs, pol;
        logic [35:0] eRgb;
        {eReq, eFs, eX, eY} = '0;
        {eBlank, eHs, eVs}  = '0;
        eRgb = '0;
        if (k >= 1) begin
            p1   = (k - 1) % c_FT;
            eReq = inAct(p1);
            eX   = p1 % c_HT;
            eY   = p1 / c_HT;
            eFs  = (p1 == 0);
        end
        if (k >= 2) begin
            p2     = (k - 2) % c_FT;
            eBlank = inAct(p2);
            eHs    = inHs(p2);
            eVs    = inVs(p2);
            eRgb   = eBlank ? rgbEdge : 36'd0;
        end
        for (int d = 0; d < 2; d++) begin
            pol = (d == 1);
            chk($sformatf("d%0d request", d),    32'(req[d]),    32'(eReq));
            chk($sformatf("d%0d x_cont", d),     32'(xc[d]),     eX);
            chk($sformatf("d%0d y_cont", d),     32'(yc[d]),     eY);
            chk($sformatf("d%0d framestart", d), 32'(fs[d]),     32'(eFs));
            chk($sformatf("d%0d blank_n", d),    32'(blankN[d]), 32'(eBlank));
            chk($sformatf("d%0d hs", d),         32'(hs[d]),     32'(eHs ? pol : !pol));
            chk($sformatf("d%0d vs", d),         32'(vs[d]),     32'(eVs ? pol : !pol));
            chk($sformatf("d%0d red", d),        32'(vr[d]),     32'(eRgb[35:24]));
            chk($sformatf("d%0d green", d),      32'(vg[d]),     32'(eRgb[23:12]));
            chk($sformatf("d%0d blue", d),       32'(vb[d]),     32'(eRgb[11:0]));
        end
    endtask

    // Whole-frame bookkeeping from the observed pins: requests and period per frame
    task automatic frameStats();
        if (k == 0) begin
            fsSeen = 1'b0;
            reqCnt = 0;
        end else begin
            if (fs[0] === 1'b1) begin
                if (fsSeen) begin
                    chk("frame_requests", reqCnt, c_HA * c_VA);
                    chk("frame_period", cyc - lastFs, c_FT);
                end
                fsSeen = 1'b1;
                lastFs = cyc;
                reqCnt = 0;
            end
            if (req[0] === 1'b1) reqCnt++;
        end
    endtask

    // FIFO model: answers each request with its index, otherwise drives junk
    task automatic step(input logic r);
        bit curReq;
        curReq = (k >= 1) ? inAct((k - 1) % c_FT) : 1'b0;
        if (curReq) begin
            red = 12'(reqIdx % 4096);
            reqIdx++;
        end else begin
            red = ($urandom % 2 == 0) ? 12'hFFF : 12'($urandom);
        end
        green = 12'($urandom);
        blue  = 12'($urandom);
        rst   = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) k = 0;
        else   k++;
        rgbEdge = {red, green, blue};
        checkAll();
        frameStats();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        k      = 0;
        cyc    = 0;
        reqIdx = 0;
        reqCnt = 0;
        lastFs = 0;
        fsSeen = 1'b0;
        rgbEdge = '0;

        repeat (5) step(1'b1);
        repeat (2 * c_FT + 10) step(1'b0);

        guard = 0;
        while (!(k >= 1 && (k - 1) % c_FT == 4 * c_HT + 8) && guard < 2 * c_FT) begin
            step(1'b0);
            guard++;
        end
        chk("midframe_reached", 32'(guard < 2 * c_FT), 32'd1);
        step(1'b1);
        repeat (c_FT + 40) step(1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 150) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
